// File: rtl/wt4_operand_loader.sv
// Serial operand loader for the 4-operand 4-bit Wallace-tree adder.
// Collects four operands, holds them for one evaluation cycle, returns the sum.
module wt4_operand_loader #(
   parameter int OP_WIDTH  = 4,
   parameter int SUM_WIDTH = 6,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [OP_WIDTH-1:0]  IN_DATA,
   input  logic                 FLUSH,
   output logic [OP_WIDTH-1:0]  NET_0_0,
   output logic [OP_WIDTH-1:0]  NET_0_1,
   output logic [OP_WIDTH-1:0]  NET_0_2,
   output logic [OP_WIDTH-1:0]  NET_0_3,
   input  logic [SUM_WIDTH-1:0] TREE_RESULT,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [SUM_WIDTH-1:0] OUT_SUM,
   output logic [CNT_WIDTH-1:0] GROUP_CNT
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      EVAL    = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t              state;
   logic [1:0]          idx;
   logic [OP_WIDTH-1:0] slot [4];

   assign NET_0_0 = slot[0];
   assign NET_0_1 = slot[1];
   assign NET_0_2 = slot[2];
   assign NET_0_3 = slot[3];

   // Loader FSM: collect four operands, sample the tree once, hold the sum.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= COLLECT;
         idx       <= '0;
         slot      <= '{default: '0};
         OUT_SUM   <= '0;
         OUT_VALID <= 1'b0;
         IN_READY  <= 1'b1;
         GROUP_CNT <= '0;
      end else begin
         unique case (state)
            COLLECT: begin
               if (FLUSH) begin
                  idx  <= '0;
                  slot <= '{default: '0};
               end else if (IN_VALID) begin
                  slot[idx] <= IN_DATA;
                  idx       <= idx + 2'd1;
                  if (idx == 2'd3) begin
                     state    <= EVAL;
                     IN_READY <= 1'b0;
                  end
               end
            end
            EVAL: begin
               OUT_SUM   <= TREE_RESULT;
               GROUP_CNT <= GROUP_CNT + CNT_WIDTH'(1);
               OUT_VALID <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (OUT_READY) begin
                  OUT_VALID <= 1'b0;
                  IN_READY  <= 1'b1;
                  state     <= COLLECT;
               end
            end
            default: begin
               state     <= COLLECT;
               idx       <= '0;
               OUT_VALID <= 1'b0;
               IN_READY  <= 1'b1;
            end
         endcase
      end
   end

endmodule
